// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data bus for loads and stores, extracts and extends
// load data, and stalls the upstream pipeline until the access completes.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_store_data,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic [2:0]  mem_funct3,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] mem_wb_candidate,
    output logic [31:0] mem_load_data,
    output logic        mem_stall,
    output logic        mem_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] load_buf;

    logic        is_load;
    logic        is_store;
    logic        access;
    logic        legal_f3;
    logic        sz_byte;
    logic        sz_half;
    logic        sz_word;
    logic        misaligned;
    logic        go;
    logic [1:0]  a;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    // The PC travels with the instruction but this stage has no use for it.
    logic        unused_pc;
    assign unused_pc = ^mem_pc;

    assign a        = mem_alu_result[1:0];
    assign is_load  = mem_mem_read;
    assign is_store = mem_mem_write & ~mem_mem_read;
    assign access   = mem_valid & (mem_mem_read | mem_mem_write);

    always_comb begin
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        legal_f3 = 1'b1;
        case (mem_funct3)
            3'b000:  sz_byte = 1'b1;
            3'b001:  sz_half = 1'b1;
            3'b010:  sz_word = 1'b1;
            3'b100: begin
                sz_byte  = 1'b1;
                legal_f3 = is_load;
            end
            3'b101: begin
                sz_half  = 1'b1;
                legal_f3 = is_load;
            end
            default: legal_f3 = 1'b0;
        endcase
    end

    assign misaligned     = ~legal_f3 | (sz_half & a[0]) | (sz_word & (a != 2'b00));
    assign mem_misaligned = access & misaligned;
    assign go             = access & ~misaligned;

    assign dbus_addr = {mem_alu_result[31:2], 2'b00};
    assign dbus_we   = mem_valid & is_store;

    always_comb begin
        dbus_wstrb = 4'b0000;
        dbus_wdata = 32'h0;
        if (is_store) begin
            if (sz_byte) begin
                dbus_wstrb = 4'b0001 << a;
                dbus_wdata = {4{mem_store_data[7:0]}};
            end else if (sz_half) begin
                dbus_wstrb = 4'b0011 << a;
                dbus_wdata = {2{mem_store_data[15:0]}};
            end else if (sz_word) begin
                dbus_wstrb = 4'b1111;
                dbus_wdata = mem_store_data;
            end
        end
    end

    // REQ holds the request regardless of inputs; upstream keeps them frozen meanwhile.
    assign dbus_req  = rst & (((state == IDLE) & go) | (state == REQ));
    assign mem_stall = ((state == IDLE) & go) | (state == REQ) | (state == WAIT);

    assign mem_load_data    = (state == DONE) ? load_buf : 32'h0;
    assign mem_wb_candidate = mem_alu_result;

    always_comb begin
        case (a)
            2'd0:    rd_byte = dbus_rdata[7:0];
            2'd1:    rd_byte = dbus_rdata[15:8];
            2'd2:    rd_byte = dbus_rdata[23:16];
            default: rd_byte = dbus_rdata[31:24];
        endcase
        rd_half = a[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (mem_funct3[1:0])
            2'b00:   load_ext = {{24{~mem_funct3[2] & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{~mem_funct3[2] & rd_half[15]}}, rd_half};
            default: load_ext = dbus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            load_buf <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        if (dbus_gnt) state <= is_store ? DONE : WAIT;
                        else          state <= REQ;
                    end
                end
                REQ: begin
                    if (dbus_gnt) state <= is_store ? DONE : WAIT;
                end
                WAIT: begin
                    if (dbus_rvalid) begin
                        load_buf <= load_ext;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
